// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_pkg
// Description : Shared TIS-node parameter header: opcode encodings and the
//               21-bit instruction word field positions, used by the opcode
//               decoder and the PC/fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_pkg;

    // Instruction word geometry
    localparam int WORD_W   = 21;
    localparam int OPC_HI   = 20;
    localparam int OPC_LO   = 17;
    localparam int OPC_W    = OPC_HI - OPC_LO + 1;
    localparam int CONST_LO = 3;    // constant field starts here; jump targets use its low bits

    // Opcode encodings seen by the PC logic
    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h8;
    localparam logic [OPC_W-1:0] OP_JEZ = 4'h9;
    localparam logic [OPC_W-1:0] OP_JNZ = 4'hA;
    localparam logic [OPC_W-1:0] OP_JGZ = 4'hB;
    localparam logic [OPC_W-1:0] OP_JLZ = 4'hC;
    localparam logic [OPC_W-1:0] OP_JRO = 4'hD;

    // Word presented to the decoder whenever no instruction is live
    localparam logic [WORD_W-1:0] NOP_WORD = {OP_NOP, {(WORD_W-OPC_W){1'b0}}};

endpackage : pc_fetch_pkg
`default_nettype wire

// File: rtl/pc_fetch_next_pc.sv
`default_nettype none
// ============================================================================
// Module      : next_pc
// Description : Purely combinational next-PC selection for one TIS node:
//               sequential with wrap, absolute/conditional jumps, and the
//               clamped relative jump (JRO) when PC_FETCH_JRO_EN is defined.
//               Without PC_FETCH_JRO_EN, JRO falls back to sequential.
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc
    import pc_fetch_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic [OPC_W-1:0]   i_opcode,
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic [ADDR_W-1:0]  i_target,
    input  logic signed [10:0] i_acc,
    input  logic signed [10:0] i_jro_val,
    input  logic [ADDR_W:0]    i_prog_len,
    output logic [ADDR_W-1:0]  o_next_pc
);

    logic [ADDR_W:0]   w_pc_inc;
    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_tgt;
    logic [ADDR_W-1:0] w_jro;
    logic              w_acc_zero;
    logic              w_acc_neg;
    logic              w_acc_pos;

    assign w_pc_inc   = {1'b0, i_pc} + {{ADDR_W{1'b0}}, 1'b1};
    assign w_seq      = (w_pc_inc == i_prog_len) ? '0 : w_pc_inc[ADDR_W-1:0];
    // Targets beyond the loaded program restart at slot 0
    assign w_tgt      = ({1'b0, i_target} < i_prog_len) ? i_target : '0;
    assign w_acc_zero = (i_acc == 11'sd0);
    assign w_acc_neg  = i_acc[10];
    assign w_acc_pos  = !w_acc_zero && !w_acc_neg;

`ifdef PC_FETCH_JRO_EN
    logic signed [11:0] w_jro_sum;
    logic signed [11:0] w_jro_max;
    logic               w_jro_unused;

    assign w_jro_sum    = $signed({{(12-ADDR_W){1'b0}}, i_pc}) + $signed({i_jro_val[10], i_jro_val});
    assign w_jro_max    = $signed({{(11-ADDR_W){1'b0}}, i_prog_len}) - 12'sd1;
    assign w_jro_unused = ^{w_jro_sum[11:ADDR_W], w_jro_max[11:ADDR_W]};

    // Clamp the relative jump into [0, prog_len-1]
    always_comb begin
        w_jro = w_jro_sum[ADDR_W-1:0];
        if (w_jro_sum < 12'sd0) begin
            w_jro = '0;
        end else if (w_jro_sum > w_jro_max) begin
            w_jro = w_jro_max[ADDR_W-1:0];
        end
    end
`else
    logic w_jro_unused;

    assign w_jro_unused = ^i_jro_val;
    assign w_jro        = w_seq;
`endif

    // Opcode-driven selection of the next PC
    always_comb begin
        o_next_pc = w_seq;
        case (i_opcode)
            OP_JMP:  o_next_pc = w_tgt;
            OP_JEZ:  o_next_pc = w_acc_zero ? w_tgt : w_seq;
            OP_JNZ:  o_next_pc = !w_acc_zero ? w_tgt : w_seq;
            OP_JGZ:  o_next_pc = w_acc_pos ? w_tgt : w_seq;
            OP_JLZ:  o_next_pc = w_acc_neg ? w_tgt : w_seq;
            OP_JRO:  o_next_pc = w_jro;
            default: o_next_pc = w_seq;
        endcase
    end

endmodule : next_pc
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch
// Description : Program counter and instruction store for one TIS node.
//               Holds the program, presents the current instruction word to
//               the decoder and advances the PC from the decoder's opcode.
//               Optional macro PC_FETCH_JRO_EN enables the clamped JRO jump.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en,
    input  logic                load_clr,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [WORD_W-1:0]   load_data,
    input  logic                run,
    input  logic                stall,
    input  logic [OPC_W-1:0]    pc_instr,
    input  logic signed [10:0]  acc,
    input  logic signed [10:0]  jro_val,
    output logic [WORD_W-1:0]   op_code,
    output logic                op_valid,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W:0]     prog_len
);

    localparam logic [0:0]        S_IDLE  = 1'b0;
    localparam logic [0:0]        S_RUN   = 1'b1;
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(PROG_DEPTH);

    logic [WORD_W-1:0] r_mem [PROG_DEPTH];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W:0]   r_prog_len;

    logic              w_idle;
    logic              w_load_wr;
    logic [ADDR_W:0]   w_len_base;
    logic [ADDR_W:0]   w_addr_len;
    logic [ADDR_W:0]   w_len_next;
    logic [WORD_W-1:0] w_mem_word;
    logic [ADDR_W-1:0] w_next_pc;

    assign w_idle     = (r_state == S_IDLE);
    // Writes outside the store are dropped and do not extend the program
    assign w_load_wr  = w_idle && load_en && ({1'b0, load_addr} < c_depth);
    // A simultaneous clear applies before the write
    assign w_len_base = load_clr ? '0 : r_prog_len;
    assign w_addr_len = {1'b0, load_addr} + {{ADDR_W{1'b0}}, 1'b1};
    assign w_len_next = (w_load_wr && (w_addr_len > w_len_base)) ? w_addr_len : w_len_base;

    assign w_mem_word = r_mem[r_pc];
    assign op_valid   = (r_state == S_RUN) && !stall;
    assign op_code    = op_valid ? w_mem_word : NOP_WORD;
    assign pc         = r_pc;
    assign prog_len   = r_prog_len;

    next_pc #(
        .ADDR_W     (ADDR_W)
    ) u_next_pc (
        .i_opcode   (pc_instr),
        .i_pc       (r_pc),
        .i_target   (op_code[ADDR_W+CONST_LO-1:CONST_LO]),
        .i_acc      (acc),
        .i_jro_val  (jro_val),
        .i_prog_len (r_prog_len),
        .o_next_pc  (w_next_pc)
    );

    // Program store write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_load_wr) begin
            r_mem[load_addr] <= load_data;
        end
    end

    // Run/idle control: only enter RUN with a non-empty program
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (run && (r_prog_len != '0)) r_state <= S_RUN;
                S_RUN:   if (!run) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Program length tracks the highest written slot while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prog_len <= '0;
        end else if (w_idle) begin
            r_prog_len <= w_len_next;
        end
    end

    // PC advances on every non-stalled RUN cycle; clear rewinds it while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (w_idle && load_clr) begin
            r_pc <= '0;
        end else if (op_valid) begin
            r_pc <= w_next_pc;
        end
    end

endmodule : pc_fetch
`default_nettype wire
